// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg : shared widths and Q10.10 saturation for the 4-point streaming FFT
// Revision: 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int DATA_W = 21;
    localparam int FRAC_W = 10;
    localparam int N      = 4;
    localparam int ACC_W  = 23;

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] sat_q10(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
        return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfly2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bfly2 : radix-2 butterfly, sum and difference at accumulator width
// Revision: 1.0
// ---------------------------------------------------------------------------
module bfly2
    import fft_pkg::*;
(
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic signed [ACC_W-1:0] diff_o
);

    assign sum_o  = a_i + b_i;
    assign diff_o = a_i - b_i;

endmodule
`default_nettype wire

// File: rtl/fft.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft : streaming 4-point real-input DFT, one sample every two clocks
// Revision: 1.0
// ---------------------------------------------------------------------------
module fft
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] outr,
    output logic [DATA_W-1:0] outi
);

    logic              phase_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] samp_q [N];
    logic [DATA_W-1:0] hold_q [N];
    logic              valid_q;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic [DATA_W-1:0] outi_q, outi_d;

    logic signed [ACC_W-1:0] a0, a1, b0, b1, nb1;
    logic signed [ACC_W-1:0] x0r, x2r, x1i, x3i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= 1'b0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            outr_q  <= '0;
            outi_q  <= '0;
            for (int i = 0; i < N; i++) begin
                samp_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            phase_q <= ~phase_q;
            outr_q  <= outr_d;
            outi_q  <= outi_d;
            if (phase_q) begin
                samp_q[cnt_q] <= in;
                cnt_q         <= cnt_q + 2'd1;
                // Slot 3 comes straight from the input so the held block is complete this edge
                if (cnt_q == 2'(N-1)) begin
                    hold_q[0] <= samp_q[0];
                    hold_q[1] <= samp_q[1];
                    hold_q[2] <= samp_q[2];
                    hold_q[3] <= in;
                    valid_q   <= 1'b1;
                end
            end
        end
    end

    bfly2 u_s1_even (.a_i(sext(hold_q[0])), .b_i(sext(hold_q[2])), .sum_o(a0),  .diff_o(a1));
    bfly2 u_s1_odd  (.a_i(sext(hold_q[1])), .b_i(sext(hold_q[3])), .sum_o(b0),  .diff_o(b1));
    bfly2 u_s2_re   (.a_i(a0),              .b_i(b0),              .sum_o(x0r), .diff_o(x2r));

    // -j*b1 is purely imaginary (-b1); the real part of X1/X3 is just a1
    assign nb1 = -b1;
    bfly2 u_s2_im   (.a_i('0),              .b_i(nb1),             .sum_o(x1i), .diff_o(x3i));

    always_comb begin
        outr_d = outr_q;
        outi_d = outi_q;
        if (phase_q && valid_q) begin
            case (cnt_q)
                2'd0: begin
                    outr_d = sat_q10(x0r);
                    outi_d = '0;
                end
                2'd1: begin
                    outr_d = sat_q10(a1);
                    outi_d = sat_q10(x1i);
                end
                2'd2: begin
                    outr_d = sat_q10(x2r);
                    outi_d = '0;
                end
                default: begin
                    outr_d = sat_q10(a1);
                    outi_d = sat_q10(x3i);
                end
            endcase
        end
    end

    assign outr = outr_q;
    assign outi = outi_q;

endmodule
`default_nettype wire

// File: tb/tb_fft.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft : table-driven scoreboard bench for the 4-point streaming FFT
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] in_s;
    logic [20:0] outr, outi;

    always #5 clk = ~clk;

    fft dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in_s),
        .outr (outr),
        .outi (outi)
    );

    typedef struct {
        logic [3:0][20:0] x;
        logic [3:0][20:0] er;
        logic [3:0][20:0] ei;
    } vec_t;

    typedef struct {
        logic [20:0] r;
        logic [20:0] i;
    } bin_t;

    vec_t tbl [7];
    vec_t flush;
    bin_t exp_q [$];
    int   e;
    int   n_chk;
    int   n_fail;

    function automatic vec_t mk(input int x0, x1, x2, x3,
                                input int r0, i0, r1, i1, r2, i2, r3, i3);
        vec_t v;
        v.x[0]  = 21'(x0); v.x[1]  = 21'(x1); v.x[2]  = 21'(x2); v.x[3]  = 21'(x3);
        v.er[0] = 21'(r0); v.er[1] = 21'(r1); v.er[2] = 21'(r2); v.er[3] = 21'(r3);
        v.ei[0] = 21'(i0); v.ei[1] = 21'(i1); v.ei[2] = 21'(i2); v.ei[3] = 21'(i3);
        return v;
    endfunction

    task automatic check(input string name, input logic [20:0] ar, ai, er, ei);
        n_chk++;
        if (ar !== er || ai !== ei) begin
            n_fail++;
            $display("FAIL %s: got (%h,%h) expected (%h,%h)", name, ar, ai, er, ei);
        end
    endtask

    // Outputs stay zero for 9 edges after release; from edge 10 each strobe emits one bin
    task automatic edge_check();
        bin_t b;
        e++;
        if (e < 10)
            check($sformatf("zero_after_release e=%0d", e), outr, outi, 21'h0, 21'h0);
        else if ((e % 2) == 0 && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check($sformatf("bin e=%0d", e), outr, outi, b.r, b.i);
        end
    endtask

    task automatic step(input logic [20:0] s);
        in_s = s;
        repeat (2) begin
            @(posedge clk);
            #1;
            edge_check();
        end
    endtask

    task automatic run_block(input vec_t v, input bit push);
        bin_t b;
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                b.r = v.er[k];
                b.i = v.ei[k];
                exp_q.push_back(b);
            end
        end
        for (int k = 0; k < 4; k++)
            step(v.x[k]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        e      = 0;

        tbl[0] = mk(1024, 2048, 3072, 4096,  10240, 0,  -2048, 2048,  -2048, 0,  -2048, -2048);
        tbl[1] = mk(1024, 1024, 1024, 1024,  4096, 0,  0, 0,  0, 0,  0, 0);
        tbl[2] = mk(1024, 0, 0, 0,           1024, 0,  1024, 0,  1024, 0,  1024, 0);
        tbl[3] = mk('h0FFFFF, 'h0FFFFF, 'h0FFFFF, 'h0FFFFF,  'h0FFFFF, 0,  0, 0,  0, 0,  0, 0);
        tbl[4] = mk('h100000, 'h100000, 'h100000, 'h100000,  'h100000, 0,  0, 0,  0, 0,  0, 0);
        tbl[5] = mk(1024, 2048, 3072, 4096,  10240, 0,  -2048, 2048,  -2048, 0,  -2048, -2048);
        tbl[6] = mk(100, -50, 30, 7,         87, 0,  70, 57,  173, 0,  70, -57);
        flush  = mk(512, 512, 512, 512,      0, 0, 0, 0, 0, 0, 0, 0);

        rst  = 1'b0;
        in_s = '0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_state", outr, outi, 21'h0, 21'h0);
        #4;
        rst = 1'b1;

        run_block(tbl[0], 1'b1);
        for (int i = 0; i < 7; i++)
            run_block(tbl[i], 1'b1);
        run_block(flush, 1'b0);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        // Two samples of a new block, then reset mid-block while stale bins are on the outputs
        step(21'd7000);
        step(21'd7001);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_clears", outr, outi, 21'h0, 21'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", outr, outi, 21'h0, 21'h0);
        #1;
        rst = 1'b1;
        e   = 0;
        exp_q.delete();

        run_block(tbl[0], 1'b1);
        run_block(flush, 1'b0);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain_after_reset: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
